// File: rtl/nn_seq_pkg.sv
// Shared definitions for the multi-layer sequencer: FSM encoding and
// the fixed four-word config layout of each layer descriptor.
package nn_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    localparam int CFG_WORDS = 4;
    localparam int CFG_IDX_W = 2;

    localparam logic [CFG_IDX_W-1:0] CFG_IDX_0    = 2'd0;
    localparam logic [CFG_IDX_W-1:0] CFG_IDX_LAST = 2'(CFG_WORDS - 1);

endpackage

// File: rtl/nn_layer_seq_if.sv
// Sequencer <-> accelerator core link: config write port, start pulse, finish.
// Handshake: the core latches o_cfg into register o_cfg_addr on every cycle
// o_cfg_wr_en is high, runs after a one-cycle o_nn_start, and answers with a
// rising edge on i_nn_finish; there is no back-pressure on the config port.
interface nn_layer_seq_if #(
    parameter int CFG_WIDTH = 16
);
    logic [CFG_WIDTH-1:0] o_cfg;
    logic [1:0]           o_cfg_addr;
    logic                 o_cfg_wr_en;
    logic                 o_nn_start;
    logic                 i_nn_finish;

    modport master (
        output o_cfg, o_cfg_addr, o_cfg_wr_en, o_nn_start,
        input  i_nn_finish
    );

    modport slave (
        input  o_cfg, o_cfg_addr, o_cfg_wr_en, o_nn_start,
        output i_nn_finish
    );
endinterface

// File: rtl/nn_layer_seq.sv
// Multi-layer scheduler: streams each layer's four descriptor words into the
// core, pulses start, waits for a fresh finish edge, with abort and watchdog.
module nn_layer_seq
    import nn_seq_pkg::*;
#(
    parameter int LAYER_NUM        = 8,
    parameter int LAYER_ADDR_WIDTH = 3,
    parameter int CFG_WIDTH        = 16,
    parameter int TIMEOUT_WIDTH    = 20
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_desc_wr_en,
    input  logic [LAYER_ADDR_WIDTH+1:0]   i_desc_wr_addr,
    input  logic [CFG_WIDTH-1:0]          i_desc_wr_data,
    input  logic [LAYER_ADDR_WIDTH:0]     i_layer_count,
    input  logic                          i_go,
    input  logic                          i_abort,
    nn_layer_seq_if.master                core,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_timeout,
    output logic [LAYER_ADDR_WIDTH-1:0]   o_cur_layer,
    output state_e                        o_state
);

    localparam int LAW = LAYER_ADDR_WIDTH;
    localparam logic [LAW:0]             LAYER_MAX = (LAW+1)'(LAYER_NUM);
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST   = {TIMEOUT_WIDTH{1'b1}} - 1'b1;

    logic [CFG_WIDTH-1:0] tbl_q [LAYER_NUM*CFG_WORDS];

    state_e                   state_q, state_d;
    logic [CFG_IDX_W-1:0]     word_q, word_d;
    logic [LAW-1:0]           layer_q, layer_d;
    logic [LAW:0]             count_q, count_d;
    logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
    logic                     fin_prev_q;
    logic                     done_q, done_d;
    logic                     timeout_q, timeout_d;
    logic [CFG_WIDTH-1:0]     cfg_q, cfg_d;
    logic [CFG_IDX_W-1:0]     cfg_addr_q, cfg_addr_d;
    logic                     cfg_wr_en_q, cfg_wr_en_d;
    logic                     start_q, start_d;
    logic                     busy_q, busy_d;
    logic                     fin_rise;
    logic [LAW:0]             sat_count;

    // Descriptor table is deliberately left unreset; host reloads it.
    always_ff @(posedge i_clk) begin
        if (i_desc_wr_en && state_q == ST_IDLE)
            tbl_q[i_desc_wr_addr] <= i_desc_wr_data;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            word_q      <= CFG_IDX_0;
            layer_q     <= '0;
            count_q     <= '0;
            wd_q        <= '0;
            fin_prev_q  <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cfg_q       <= '0;
            cfg_addr_q  <= '0;
            cfg_wr_en_q <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            layer_q     <= layer_d;
            count_q     <= count_d;
            wd_q        <= wd_d;
            fin_prev_q  <= core.i_nn_finish;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            cfg_q       <= cfg_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wr_en_q <= cfg_wr_en_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
        end
    end

    // Only a fresh edge counts, so a finish level left over from the
    // previous layer cannot complete the next one.
    assign fin_rise  = core.i_nn_finish & ~fin_prev_q;
    assign sat_count = (i_layer_count > LAYER_MAX) ? LAYER_MAX : i_layer_count;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        layer_d   = layer_q;
        count_d   = count_q;
        wd_d      = wd_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (i_go) begin
                    count_d   = sat_count;
                    timeout_d = 1'b0;
                    if (sat_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        layer_d = '0;
                        word_d  = CFG_IDX_0;
                    end
                end
            end
            ST_LOAD: begin
                if (word_q == CFG_IDX_LAST) state_d = ST_START;
                else                        word_d  = word_q + 1'b1;
            end
            ST_START: begin
                state_d = ST_WAIT;
                wd_d    = '0;
            end
            ST_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (fin_rise) begin
                    if ({1'b0, layer_q} == count_q - 1'b1) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        layer_d = layer_q + 1'b1;
                        word_d  = CFG_IDX_0;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort outranks finish and timeout; the sticky flag is left alone.
        if (i_abort && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            layer_d   = layer_q;
            done_d    = 1'b0;
            timeout_d = timeout_q;
        end
    end

    always_comb begin
        cfg_wr_en_d = (state_d == ST_LOAD);
        cfg_addr_d  = cfg_wr_en_d ? word_d : CFG_IDX_0;
        cfg_d       = cfg_wr_en_d ? tbl_q[{layer_d, word_d}] : '0;
        start_d     = (state_d == ST_START);
        busy_d      = (state_d != ST_IDLE);
    end

    assign core.o_cfg       = cfg_q;
    assign core.o_cfg_addr  = cfg_addr_q;
    assign core.o_cfg_wr_en = cfg_wr_en_q;
    assign core.o_nn_start  = start_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_timeout        = timeout_q;
    assign o_cur_layer      = layer_q;
    assign o_state          = state_q;

endmodule

// File: tb/tb_nn_layer_seq.sv
// Directed bench for nn_layer_seq with a short watchdog so timeout is reachable.
module tb_nn_layer_seq;
    import nn_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        desc_wr_en;
    logic [4:0]  desc_wr_addr;
    logic [15:0] desc_wr_data;
    logic [3:0]  layer_count;
    logic        go;
    logic        abort_s;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [2:0]  cur_layer;
    state_e      state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    nn_layer_seq_if #(.CFG_WIDTH(16)) core_if ();

    nn_layer_seq #(
        .LAYER_NUM(8), .LAYER_ADDR_WIDTH(3), .CFG_WIDTH(16), .TIMEOUT_WIDTH(4)
    ) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_desc_wr_en(desc_wr_en), .i_desc_wr_addr(desc_wr_addr),
        .i_desc_wr_data(desc_wr_data), .i_layer_count(layer_count),
        .i_go(go), .i_abort(abort_s), .core(core_if.master),
        .o_busy(busy), .o_done(done), .o_timeout(timeout),
        .o_cur_layer(cur_layer), .o_state(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic desc_wr(input int layer, input int word, input logic [15:0] data);
        desc_wr_en   = 1'b1;
        desc_wr_addr = 5'(layer * 4 + word);
        desc_wr_data = data;
        tick();
        desc_wr_en   = 1'b0;
    endtask

    task automatic go_pulse(input logic [3:0] cnt);
        layer_count = cnt;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    initial begin
        int starts;
        int cd;
        bit done_seen;
        bit bad;
        rst_n = 1'b0; desc_wr_en = 1'b0; desc_wr_addr = '0; desc_wr_data = '0;
        layer_count = '0; go = 1'b0; abort_s = 1'b0; core_if.i_nn_finish = 1'b0;
        ticks(3);
        check("rst_wr_en", 32'(core_if.o_cfg_wr_en), 0);
        check("rst_cfg", 32'(core_if.o_cfg), 0);
        check("rst_start", 32'(core_if.o_nn_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_layer", 32'(cur_layer), 0);
        rst_n = 1'b1;
        tick();

        for (int w = 0; w < 4; w++) desc_wr(0, w, 16'h1111 * 16'(w + 1));
        for (int w = 0; w < 4; w++) desc_wr(1, w, 16'hA0A0 + 16'h1010 * 16'(w));

        // Two layers; first finish lands on the watchdog's last cycle.
        go_pulse(4'd2);
        for (int w = 0; w < 4; w++) begin
            check("l0_wr_en", 32'(core_if.o_cfg_wr_en), 1);
            check("l0_addr", 32'(core_if.o_cfg_addr), 32'(w));
            check("l0_cfg", 32'(core_if.o_cfg), 32'(16'h1111 * 16'(w + 1)));
            tick();
        end
        check("l0_start", 32'(core_if.o_nn_start), 1);
        check("l0_start_wr", 32'(core_if.o_cfg_wr_en), 0);
        tick();
        check("l0_start_once", 32'(core_if.o_nn_start), 0);
        check("l0_busy", 32'(busy), 1);
        ticks(14);
        core_if.i_nn_finish = 1'b1;
        tick();
        core_if.i_nn_finish = 1'b0;
        check("fin_beats_to", 32'(timeout), 0);
        check("l1_layer", 32'(cur_layer), 1);
        for (int w = 0; w < 4; w++) begin
            check("l1_wr_en", 32'(core_if.o_cfg_wr_en), 1);
            check("l1_addr", 32'(core_if.o_cfg_addr), 32'(w));
            check("l1_cfg", 32'(core_if.o_cfg), 32'(16'hA0A0 + 16'h1010 * 16'(w)));
            tick();
        end
        check("l1_start", 32'(core_if.o_nn_start), 1);
        ticks(2);
        core_if.i_nn_finish = 1'b1;
        tick();
        core_if.i_nn_finish = 1'b0;
        check("seq_done", 32'(done), 1);
        check("seq_idle", 32'(busy), 0);
        check("seq_layer_hold", 32'(cur_layer), 1);
        tick();
        check("done_pulse", 32'(done), 0);

        // Zero layers: immediate done, nothing driven to the core.
        go_pulse(4'd0);
        check("zero_done", 32'(done), 1);
        check("zero_wr_en", 32'(core_if.o_cfg_wr_en), 0);
        check("zero_busy", 32'(busy), 0);
        tick();
        check("zero_start", 32'(core_if.o_nn_start), 0);

        // Count above table depth saturates at 8 layers.
        go_pulse(4'd12);
        starts = 0; cd = 0; done_seen = 0;
        for (int c = 0; c < 300 && !done_seen; c++) begin
            core_if.i_nn_finish = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) core_if.i_nn_finish = 1'b1;
            end
            if (core_if.o_nn_start) begin
                starts++;
                cd = 3;
            end
            if (done) done_seen = 1;
            if (!done_seen) tick();
        end
        core_if.i_nn_finish = 1'b0;
        check("sat_starts", 32'(starts), 8);
        check("sat_done", 32'(done_seen), 1);
        check("sat_layer", 32'(cur_layer), 7);

        // Watchdog: no finish, timeout after 15 WAIT cycles.
        go_pulse(4'd1);
        ticks(19);
        check("to_before", 32'(timeout), 0);
        check("to_busy_before", 32'(busy), 1);
        tick();
        check("to_flag", 32'(timeout), 1);
        check("to_idle", 32'(busy), 0);
        check("to_no_done", 32'(done), 0);
        ticks(3);
        check("to_sticky", 32'(timeout), 1);
        go_pulse(4'd0);
        check("to_cleared", 32'(timeout), 0);

        // Abort during word 2, with a descriptor write attempted while busy.
        go_pulse(4'd1);
        desc_wr(0, 0, 16'hDEAD);
        check("ab_busy", 32'(busy), 1);
        tick();
        check("ab_word2", 32'(core_if.o_cfg_addr), 2);
        abort_s = 1'b1;
        tick();
        abort_s = 1'b0;
        check("ab_wr_en", 32'(core_if.o_cfg_wr_en), 0);
        check("ab_busy_low", 32'(busy), 0);
        check("ab_no_done", 32'(done), 0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (core_if.o_nn_start || done) bad = 1;
            tick();
        end
        check("ab_quiet", 32'(bad), 0);
        go_pulse(4'd1);
        check("ab_table_kept", 32'(core_if.o_cfg), 32'h1111);
        ticks(4);
        check("ab_rerun_start", 32'(core_if.o_nn_start), 1);
        tick();
        core_if.i_nn_finish = 1'b1;
        tick();
        core_if.i_nn_finish = 1'b0;
        check("ab_rerun_done", 32'(done), 1);

        // Finish held high across the layer boundary, then finish+abort.
        go_pulse(4'd2);
        ticks(5);
        core_if.i_nn_finish = 1'b1;
        tick();
        check("hold_adv", 32'(cur_layer), 1);
        check("hold_load", 32'(core_if.o_cfg_wr_en), 1);
        ticks(4);
        check("hold_start", 32'(core_if.o_nn_start), 1);
        ticks(5);
        check("hold_no_done", 32'(done), 0);
        check("hold_busy", 32'(busy), 1);
        core_if.i_nn_finish = 1'b0;
        tick();
        core_if.i_nn_finish = 1'b1;
        abort_s = 1'b1;
        tick();
        core_if.i_nn_finish = 1'b0;
        abort_s = 1'b0;
        check("fa_no_done", 32'(done), 0);
        check("fa_idle", 32'(busy), 0);
        check("fa_timeout", 32'(timeout), 0);
        tick();
        check("fa_no_done_late", 32'(done), 0);

        // go together with abort in IDLE is still accepted.
        abort_s = 1'b1;
        go_pulse(4'd0);
        abort_s = 1'b0;
        check("go_abort_idle", 32'(done), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/nn_layer_seq.md
Name: nn_layer_seq

Overview:
Multi-layer scheduler in front of the nn accelerator core. It holds a small descriptor table (four 16-bit config words per layer), loads each layer's words into the core's config port, pulses start, and waits for finish before moving on. Sits between the host/bus and the core's i_cfg/i_cfg_addr/i_cfg_wr_en/i_start/o_finish pins. Provides abort, a finish watchdog and status.

Parameters:
LAYER_NUM, 8, descriptor table depth (layers)
LAYER_ADDR_WIDTH, 3, log2(LAYER_NUM)
CFG_WIDTH, 16, config word width (matches core i_cfg)
TIMEOUT_WIDTH, 20, watchdog counter width; timeout at 2^TIMEOUT_WIDTH-1 cycles in WAIT

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  reset, asynchronous, active-low
i_desc_wr_en  in  1  descriptor table write strobe
i_desc_wr_addr  in  LAYER_ADDR_WIDTH+2  {layer index, word index[1:0]}
i_desc_wr_data  in  CFG_WIDTH  descriptor word
i_layer_count  in  LAYER_ADDR_WIDTH+1  layers to run, sampled on accepted i_go
i_go  in  1  start sequence (level, acted on only in IDLE)
i_abort  in  1  abort sequence
i_nn_finish  in  1  core finish (level or pulse)
o_cfg  out  CFG_WIDTH  config word to core
o_cfg_addr  out  2  config register index to core
o_cfg_wr_en  out  1  config write strobe to core
o_nn_start  out  1  one-cycle start pulse to core
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse on successful completion
o_timeout  out  1  sticky watchdog error flag
o_cur_layer  out  LAYER_ADDR_WIDTH  layer currently being loaded/run

Behaviour:
- All outputs registered. Reset: o_cfg=0, o_cfg_addr=0, o_cfg_wr_en=0, o_nn_start=0, o_busy=0, o_done=0, o_timeout=0, o_cur_layer=0, state IDLE, finish-edge register=0, descriptor table not reset.
- Table: register array, written when i_desc_wr_en=1 and state=IDLE; writes while busy are ignored. Word k of a layer goes to core cfg register k.
- Finish detection: rising edge of i_nn_finish (registered previous value), so a level held from a prior layer is not re-counted.
- States: IDLE, LOAD, START, WAIT.
- IDLE: i_go=1 at cycle T -> latch count = min(i_layer_count, LAYER_NUM), clear o_timeout. If count=0 -> o_done=1 at T+1, stay IDLE. Otherwise LOAD, layer=0.
- LOAD: 4 cycles, word counter 0..3; o_cfg_wr_en=1, o_cfg_addr=counter, o_cfg=table[layer][counter]. First layer: writes visible T+1..T+4.
- START: o_nn_start=1 for exactly one cycle (T+5 for first layer); watchdog cleared.
- WAIT: watchdog increments each cycle. On a finish rising edge: if layer=count-1 -> o_done pulse next cycle, IDLE; else layer+1 -> LOAD (no idle gap). Edges seen outside WAIT are ignored.
- Watchdog saturates at all-ones without finish -> o_timeout=1 (sticky until next accepted go), IDLE, no o_done.
- i_abort=1 in any non-IDLE state -> IDLE next cycle, all strobes low, no o_done, o_timeout unchanged. i_abort in IDLE: no effect.
- Priorities, same cycle: abort > finish > timeout. i_go with i_abort in IDLE: go accepted.
- i_go while busy: ignored. o_cur_layer holds last value in IDLE.
- Async reset mid-operation: immediate return to reset values. The core is not notified.

Decomposition:
- Shared package nn_seq_pkg: state encoding constants (IDLE/LOAD/START/WAIT), CFG_WORDS=4, cfg index constants.
- Single module. The descriptor table is inline; no sub-module is needed.

Test Plan:
- Load 2 layers (layer0 words 0x1111..0x4444, layer1 0xA0A0..0xD0D0), count=2, go at T -> writes addr0..3 at T+1..T+4 with 0x1111..0x4444, start at T+5; finish pulse at T+20 -> layer1 writes T+21..T+24, start T+25; finish -> single o_done, o_busy low.
- count=0, go -> o_done at T+1, no cfg_wr_en or start.
- count=12 (>LAYER_NUM=8) -> exactly 8 start pulses, then done.
- TIMEOUT_WIDTH=4, no finish -> o_timeout=1 after 15 WAIT cycles, IDLE, no done. Next go clears o_timeout.
- Abort during LOAD word 2 -> next cycle cfg_wr_en=0, busy=0, no start, no done. Descriptor write while busy -> table unchanged (verify on rerun).
- i_nn_finish held high across layer boundary -> layer advances only on the fresh rising edge. Finish and abort in the same cycle -> abort wins, no done.
